mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_starve_ctr.sv | 35 +++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   owner_t     : tag recording which requester owns the read returning next cycle
//   *_DEF       : default values for the arbiter parameters
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_t;

  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 8;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_starve_ctr.sv
// Saturating DMA starvation counter.
//   clk, rst  : clock and synchronous active-high reset
//   dma_req   : DMA is requesting this cycle
//   dma_gnt   : DMA was granted this cycle
//   starved   : counter has reached STARVE_MAX; DMA must win the next arbitration
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic starved
);

  localparam int             CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values that existed before the clock edge.
  always_ff @(posedge clk) begin
    if (rst || !dma_req || dma_gnt) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign starved = (cnt == CNT_MAX);

endmodule : mem_arb_starve_ctr

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port RAM (registered read, 1-cycle latency)
// between instruction fetch (IF), the MEM stage and an optional video DMA.
// Priority is MEM > IF > DMA; a DMA starved for STARVE_MAX cycles wins outright.
//   clk, rst                                 : clock, synchronous active-high reset
//   if_req/if_addr -> if_rdata/if_rvalid/if_stall
//   mem_req/mem_we/mem_addr/mem_wdata -> mem_rdata/mem_rvalid/mem_stall
//   dma_req/dma_addr -> dma_gnt/dma_rdata/dma_rvalid   (only with MEM_ARB_DMA_EN)
//   ram_addr/ram_we/ram_wdata -> RAM, ram_rdata <- RAM
// Build option: define MEM_ARB_DMA_EN to include the DMA port, DMA arbitration
// and the starvation counter. Without it arbitration is MEM > IF, same timing.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rvalid,
  output logic              mem_stall,
`ifdef MEM_ARB_DMA_EN
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
`endif
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  if (STARVE_MAX < 1) begin : g_param_check
    $error("STARVE_MAX must be at least 1");
  end

  logic              gnt_if;
  logic              gnt_mem;
  logic              gnt_dma;
  owner_t            owner_d;
  owner_t            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] if_held;
  logic [DATA_W-1:0] mem_held;

`ifdef MEM_ARB_DMA_EN
  logic              starved;
  logic [DATA_W-1:0] dma_held;

  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk     (clk),
    .rst     (rst),
    .dma_req (dma_req),
    .dma_gnt (gnt_dma),
    .starved (starved)
  );
`endif

  // Grant is purely combinational from this cycle's requests; nothing is
  // granted while rst is high, so the stalls simply follow the requests.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    gnt_if  = 1'b0;
    gnt_mem = 1'b0;
    gnt_dma = 1'b0;
    if (!rst) begin
`ifdef MEM_ARB_DMA_EN
      if (dma_req && starved) gnt_dma = 1'b1;
      else if (mem_req)       gnt_mem = 1'b1;
      else if (if_req)        gnt_if  = 1'b1;
      else if (dma_req)       gnt_dma = 1'b1;
`else
      if (mem_req)     gnt_mem = 1'b1;
      else if (if_req) gnt_if  = 1'b1;
`endif
    end
  end

  // RAM request mux; with no grant the address holds and no write occurs.
  always_comb begin
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    owner_d   = OWN_NONE;
    if (rst) begin
      ram_addr = '0;
    end else if (gnt_mem) begin
      ram_addr  = mem_addr;
      ram_we    = mem_we;
      ram_wdata = mem_wdata;
      owner_d   = mem_we ? OWN_NONE : OWN_MEM;
    end else if (gnt_if) begin
      ram_addr = if_addr;
      owner_d  = OWN_IF;
    end else if (gnt_dma) begin
`ifdef MEM_ARB_DMA_EN
      ram_addr = dma_addr;
`endif
      owner_d  = OWN_DMA;
    end
  end

  // Read-owner tag and per-requester hold registers. The rvalids are also
  // masked by rst so a read granted just before reset is never delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      addr_q   <= '0;
      if_held  <= '0;
      mem_held <= '0;
`ifdef MEM_ARB_DMA_EN
      dma_held <= '0;
`endif
    end else begin
      owner_q <= owner_d;
      addr_q  <= ram_addr;
      if (if_rvalid)  if_held  <= ram_rdata;
      if (mem_rvalid) mem_held <= ram_rdata;
`ifdef MEM_ARB_DMA_EN
      if (dma_rvalid) dma_held <= ram_rdata;
`endif
    end
  end

  assign if_rvalid  = !rst && (owner_q == OWN_IF);
  assign mem_rvalid = !rst && (owner_q == OWN_MEM);
  assign if_rdata   = if_rvalid  ? ram_rdata : if_held;
  assign mem_rdata  = mem_rvalid ? ram_rdata : mem_held;
  assign if_stall   = if_req  && !gnt_if;
  assign mem_stall  = mem_req && !gnt_mem;

`ifdef MEM_ARB_DMA_EN
  assign dma_gnt    = gnt_dma;
  assign dma_rvalid = !rst && (owner_q == OWN_DMA);
  assign dma_rdata  = dma_rvalid ? ram_rdata : dma_held;
`endif

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port RAM
// (registered read, 1-cycle latency). RAM word i is preloaded with
// 0xA000_0000 + i, except word 5 which holds 0xDEADBEEF. Inputs change 1ns
// after the rising edge; outputs are compared on the falling edge.
// DMA scenarios are compiled in only when MEM_ARB_DMA_EN is defined.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_rvalid;
  logic              if_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              mem_stall;
`ifdef MEM_ARB_DMA_EN
  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
`endif
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_rvalid  (if_rvalid),
    .if_stall   (if_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_stall  (mem_stall),
`ifdef MEM_ARB_DMA_EN
    .dma_req    (dma_req),
    .dma_addr   (dma_addr),
    .dma_gnt    (dma_gnt),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
`endif
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to 1ns after the next rising edge, where new inputs are applied.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
`ifdef MEM_ARB_DMA_EN
    dma_req   = 1'b0;
    dma_addr  = '0;
`endif
  endtask

  task automatic mem_read(input logic [ADDR_W-1:0] a);
    idle_inputs();
    mem_req  = 1'b1;
    mem_addr = a;
  endtask

  task automatic if_read(input logic [ADDR_W-1:0] a);
    idle_inputs();
    if_req  = 1'b1;
    if_addr = a;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'hA000_0000 + DATA_W'(i);
    ram[5]    = 32'hDEAD_BEEF;
    ram_rdata = '0;
    rst = 1'b1;
    idle_inputs();

    // Reset: no grants, stall follows request, everything else at zero.
    next_cycle();
    if_req = 1'b1;
    @(negedge clk);
    check("rst_if_stall",   if_stall,   1);
    check("rst_if_rvalid",  if_rvalid,  0);
    check("rst_mem_rvalid", mem_rvalid, 0);
    check("rst_ram_we",     ram_we,     0);
    check("rst_ram_addr",   ram_addr,   0);
    check("rst_if_rdata",   if_rdata,   0);
    check("rst_mem_rdata",  mem_rdata,  0);

    // Lone IF read of address 5.
    next_cycle();
    rst = 1'b0;
    if_read(5);
    @(negedge clk);
    check("if_alone_stall", if_stall, 0);
    check("if_alone_addr",  ram_addr, 5);
    check("if_alone_we",    ram_we,   0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("if_alone_rvalid", if_rvalid,  1);
    check("if_alone_rdata",  if_rdata,   32'hDEAD_BEEF);
    check("if_alone_mrv",    mem_rvalid, 0);
    check("idle_addr_hold",  ram_addr,   5);
    next_cycle();
    @(negedge clk);
    check("if_rvalid_drop", if_rvalid, 0);
    check("if_rdata_hold",  if_rdata,  32'hDEAD_BEEF);

    // MEM write to 3 collides with IF read of 7: MEM wins, IF follows.
    next_cycle();
    idle_inputs();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 3; mem_wdata = 32'h1234;
    if_req  = 1'b1; if_addr = 7;
    @(negedge clk);
    check("wr_ram_we",    ram_we,    1);
    check("wr_ram_addr",  ram_addr,  3);
    check("wr_ram_wdata", ram_wdata, 32'h1234);
    check("wr_if_stall",  if_stall,  1);
    check("wr_mem_stall", mem_stall, 0);
    next_cycle();
    if_read(7);
    @(negedge clk);
    check("wr_if_next_stall", if_stall,   0);
    check("wr_if_next_addr",  ram_addr,   7);
    check("wr_no_mem_rvalid", mem_rvalid, 0);
    check("wr_no_if_rvalid",  if_rvalid,  0);
    next_cycle();
    mem_read(3);
    @(negedge clk);
    check("if7_rvalid", if_rvalid, 1);
    check("if7_rdata",  if_rdata,  32'hA000_0007);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("rdback_rvalid", mem_rvalid, 1);
    check("rdback_rdata",  mem_rdata,  32'h1234);

    // Alternating MEM/IF reads: one rvalid per cycle, idle side holds.
    next_cycle(); mem_read(10);
    @(negedge clk);
    check("alt0_mem_rvalid", mem_rvalid, 0);
    next_cycle(); if_read(11);
    @(negedge clk);
    check("alt1_mem_rvalid", mem_rvalid, 1);
    check("alt1_mem_rdata",  mem_rdata,  32'hA000_000A);
    check("alt1_if_rvalid",  if_rvalid,  0);
    check("alt1_if_hold",    if_rdata,   32'hA000_0007);
    next_cycle(); mem_read(12);
    @(negedge clk);
    check("alt2_if_rvalid",  if_rvalid,  1);
    check("alt2_if_rdata",   if_rdata,   32'hA000_000B);
    check("alt2_mem_rvalid", mem_rvalid, 0);
    check("alt2_mem_hold",   mem_rdata,  32'hA000_000A);
    next_cycle(); if_read(13);
    @(negedge clk);
    check("alt3_mem_rvalid", mem_rvalid, 1);
    check("alt3_mem_rdata",  mem_rdata,  32'hA000_000C);
    check("alt3_if_hold",    if_rdata,   32'hA000_000B);
    next_cycle(); idle_inputs();
    @(negedge clk);
    check("alt4_if_rvalid",  if_rvalid,  1);
    check("alt4_if_rdata",   if_rdata,   32'hA000_000D);
    check("alt4_mem_hold",   mem_rdata,  32'hA000_000C);

    // MEM read granted, then reset: the read is never delivered.
    next_cycle(); mem_read(20);
    @(negedge clk);
    check("prerst_addr", ram_addr, 20);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("inrst_mem_rvalid", mem_rvalid, 0);
    check("inrst_mem_stall",  mem_stall,  1);
    check("inrst_ram_addr",   ram_addr,   0);
    check("inrst_ram_we",     ram_we,     0);
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("postrst_mem_rvalid", mem_rvalid, 0);
    check("postrst_if_rvalid",  if_rvalid,  0);
    check("postrst_mem_rdata",  mem_rdata,  0);
    check("postrst_if_rdata",   if_rdata,   0);
    check("postrst_ram_addr",   ram_addr,   0);

`ifdef MEM_ARB_DMA_EN
    // DMA held with IF requesting every cycle: forced grant at cycle 8 only.
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      if_read(1);
      dma_req  = 1'b1;
      dma_addr = 30;
      @(negedge clk);
      check($sformatf("starve%0d_gnt", k),   dma_gnt,  (k == 8));
      check($sformatf("starve%0d_stall", k), if_stall, (k == 8));
      if (k == 8) check("starve_addr", ram_addr, 30);
      if (k == 9) begin
        check("starve_dma_rvalid", dma_rvalid, 1);
        check("starve_dma_rdata",  dma_rdata,  32'hA000_001E);
        check("starve_if_rvalid",  if_rvalid,  0);
      end
    end
    // A lone DMA request is granted immediately.
    next_cycle();
    idle_inputs();
    dma_req = 1'b1; dma_addr = 31;
    @(negedge clk);
    check("dma_alone_gnt",  dma_gnt,  1);
    check("dma_alone_addr", ram_addr, 31);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("dma_alone_rvalid", dma_rvalid, 1);
    check("dma_alone_rdata",  dma_rdata,  32'hA000_001F);
`endif

    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_mem_port_arbiter
